// File: rtl/gate_identifier_if.sv
// Bus between the truth-table sweeper and the two-input gate under test.
// The master side requests sweeps and returns the gate output; the slave
// side (gate_identifier) drives the gate inputs and reports the result.
interface gate_if;
    logic       start;  // request a sweep
    logic       s;      // gate-under-test output
    logic       x;      // gate input a
    logic       y;      // gate input b
    logic       busy;   // sweep in progress
    logic       done;   // one-cycle result-loaded pulse
    logic [3:0] tt;     // captured truth table, tt[{x,y}]
    logic [2:0] code;   // decoded gate function
    logic       valid;  // code is non-zero

    modport master (
        output start, s,
        input  x, y, busy, done, tt, code, valid
    );

    modport slave (
        input  start, s,
        output x, y, busy, done, tt, code, valid
    );
endinterface

// File: rtl/gate_identifier.sv
// Sequential truth-table sweeper for two-input gates. On start it steps
// {x,y} through 00,01,10,11, holding each for SETTLE cycles, samples s at
// the end of each hold, then loads the truth table and its decoded
// function code together with a one-cycle done pulse.
module gate_identifier #(
    parameter int unsigned SETTLE = 2   // hold cycles per combination, 1..15
) (
    input  logic clk,
    input  logic rst_n,
    gate_if.slave bus
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    typedef enum logic [2:0] {
        FN_NONE = 3'd0,
        FN_AND  = 3'd1,
        FN_OR   = 3'd2,
        FN_NAND = 3'd3,
        FN_NOR  = 3'd4,
        FN_XOR  = 3'd5,
        FN_XNOR = 3'd6
    } fn_e;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q,   idx_d;     // current combination
    logic [3:0] cnt_q,   cnt_d;     // settle counter
    logic [2:0] cap_q,   cap_d;     // samples for combinations 0..2
    logic [1:0] xy_q,    xy_d;      // {x,y} driven to the gate
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic [3:0] tt_q,    tt_d;
    fn_e        code_q,  code_d;
    logic       valid_q, valid_d;

    // Map a captured truth table onto the gate library functions.
    function automatic fn_e decode(input logic [3:0] t);
        case (t)
            4'b1000: decode = FN_AND;
            4'b1110: decode = FN_OR;
            4'b0111: decode = FN_NAND;
            4'b0001: decode = FN_NOR;
            4'b0110: decode = FN_XOR;
            4'b1001: decode = FN_XNOR;
            default: decode = FN_NONE;
        endcase
    endfunction

    // State and output registers; reset aborts any sweep and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            // NOTE: the capture bits are reset like every other register so a
            // reset-aborted sweep can never leak stale samples into a later tt.
            cap_q   <= 3'd0;
            xy_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= 4'd0;
            code_q  <= FN_NONE;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            xy_q    <= xy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: accept start in IDLE, step combinations in SWEEP.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        xy_d    = xy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        code_d  = code_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    xy_d    = 2'b00;
                    busy_d  = 1'b1;
                end
            end

            SWEEP: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd0;
                    if (idx_q != 2'd3) begin
                        case (idx_q)
                            2'd0:    cap_d[0] = bus.s;
                            2'd1:    cap_d[1] = bus.s;
                            default: cap_d[2] = bus.s;
                        endcase
                        idx_d = idx_q + 2'd1;
                        xy_d  = idx_q + 2'd1;
                    end else begin
                        // Last combination: s goes straight into tt[3].
                        tt_d    = {bus.s, cap_q};
                        code_d  = decode({bus.s, cap_q});
                        valid_d = (decode({bus.s, cap_q}) != FN_NONE);
                        idx_d   = 2'd0;
                        xy_d    = 2'b00;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.x     = xy_q[1];
    assign bus.y     = xy_q[0];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tt    = tt_q;
    assign bus.code  = code_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Self-checking bench for gate_identifier. Two instances (SETTLE=2 and
// SETTLE=1) each sweep a behavioural gate; expected results are pushed to a
// scoreboard when a sweep is requested and popped when done rises.
module tb_gate_identifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_if bus_a ();
    gate_if bus_b ();

    // Behavioural gates under test: gate_x[{a,b}] is the gate output.
    logic [3:0] gate_a = 4'b0000;
    logic [3:0] gate_b = 4'b0000;
    assign bus_a.s = gate_a[{bus_a.x, bus_a.y}];
    assign bus_b.s = gate_b[{bus_b.x, bus_b.y}];

    gate_identifier #(.SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    gate_identifier #(.SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct packed {
        logic [3:0] tt;
        logic [2:0] code;
        logic       valid;
    } res_t;

    typedef struct packed {
        logic x;
        logic y;
        logic busy;
        logic done;
        res_t r;
    } obs_t;

    res_t sb_a[$];
    res_t sb_b[$];
    res_t last_r [2];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference decode of a truth table into the library function code.
    function automatic res_t model(input logic [3:0] g);
        res_t m;
        m.tt = g;
        case (g)
            4'b1000: m.code = 3'd1;
            4'b1110: m.code = 3'd2;
            4'b0111: m.code = 3'd3;
            4'b0001: m.code = 3'd4;
            4'b0110: m.code = 3'd5;
            4'b1001: m.code = 3'd6;
            default: m.code = 3'd0;
        endcase
        m.valid = (m.code != 3'd0);
        return m;
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) o = {bus_b.x, bus_b.y, bus_b.busy, bus_b.done, bus_b.tt, bus_b.code, bus_b.valid};
        else     o = {bus_a.x, bus_a.y, bus_a.busy, bus_a.done, bus_a.tt, bus_a.code, bus_a.valid};
        return o;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_b.start = v;
        else     bus_a.start = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on one instance, checking {x,y} stepping, busy, the held
    // result during the sweep, done latency and the loaded result.
    task automatic sweep(input bit sel, input logic [3:0] g, input bit repulse, input string name);
        int   settle = sel ? 1 : 2;
        obs_t o;
        res_t e;
        if (sel) gate_b = g;
        else     gate_a = g;
        set_start(sel, 1'b1);
        step();                                  // edge E0 accepts start
        set_start(sel, 1'b0);
        if (sel) sb_b.push_back(model(g));
        else     sb_a.push_back(model(g));
        for (int t = 0; t < 4 * settle; t++) begin
            o = sample(sel);
            n_vec++;
            if ({o.x, o.y, o.busy, o.done} !== {2'(t / settle), 2'b10}) begin
                n_err++;
                $display("FAIL %s seq t=%0d {x,y,busy,done}: got %b expected %b",
                         name, t, {o.x, o.y, o.busy, o.done}, {2'(t / settle), 2'b10});
            end
            n_vec++;
            if (o.r !== last_r[sel]) begin
                n_err++;
                $display("FAIL %s hold t=%0d {tt,code,valid}: got %b expected %b",
                         name, t, o.r, last_r[sel]);
            end
            set_start(sel, repulse && (t == 3 || t == 5));
            step();
        end
        set_start(sel, 1'b0);
        o = sample(sel);
        n_vec++;
        if ({o.x, o.y, o.busy, o.done} !== 4'b0001) begin
            n_err++;
            $display("FAIL %s done-edge {x,y,busy,done}: got %b expected 0001",
                     name, {o.x, o.y, o.busy, o.done});
        end
        if ((sel ? sb_b.size() : sb_a.size()) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard: got empty expected one entry", name);
        end else begin
            e = sel ? sb_b.pop_front() : sb_a.pop_front();
            n_vec++;
            if (o.r !== e) begin
                n_err++;
                $display("FAIL %s result {tt,code,valid}: got %b expected %b", name, o.r, e);
            end
            last_r[sel] = e;
        end
        step();
        o = sample(sel);
        n_vec++;
        if ({o.busy, o.done} !== 2'b00) begin
            n_err++;
            $display("FAIL %s after-done {busy,done}: got %b expected 00", name, {o.busy, o.done});
        end
    endtask

    task automatic test_reset();
        obs_t o;
        #12;
        for (int s = 0; s < 2; s++) begin
            o = sample(s[0]);
            n_vec++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL reset dut%0d outputs: got %b expected 0", s, o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        o = sample(1'b0);
        n_vec++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL post-reset idle outputs: got %b expected 0", o);
        end
    endtask

    task automatic test_gates();
        sweep(1'b0, 4'b0111, 1'b0, "nand");
        sweep(1'b0, 4'b0110, 1'b0, "xor");
        sweep(1'b0, 4'b1001, 1'b0, "xnor");
        sweep(1'b0, 4'b1110, 1'b0, "or");
        sweep(1'b0, 4'b1000, 1'b0, "and");
    endtask

    task automatic test_no_match();
        sweep(1'b0, 4'b1111, 1'b0, "tied_high");
    endtask

    task automatic test_ignored_start();
        sweep(1'b0, 4'b0111, 1'b1, "repulse");
    endtask

    task automatic test_back_to_back();
        int   cycles;
        obs_t o;
        res_t e;
        gate_a = 4'b0110;
        bus_a.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_a.push_back(model(gate_a));
            cycles = 0;
            do begin
                step();
                cycles++;
            end while (!bus_a.done && cycles < 20);
            if (i == 2) bus_a.start = 1'b0;
            n_vec++;
            if (cycles != 9) begin
                n_err++;
                $display("FAIL b2b sweep %0d done interval: got %0d expected 9", i, cycles);
            end
            o = sample(1'b0);
            e = sb_a.pop_front();
            n_vec++;
            if (o.r !== e) begin
                n_err++;
                $display("FAIL b2b sweep %0d result: got %b expected %b", i, o.r, e);
            end
            last_r[0] = e;
        end
        step();
        n_vec++;
        if ({bus_a.busy, bus_a.done} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b release {busy,done}: got %b expected 00", {bus_a.busy, bus_a.done});
        end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        int   dones = 0;
        gate_a = 4'b0111;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        sb_a.push_back(model(gate_a));
        repeat (4) step();                       // combination 10 now driven
        n_vec++;
        if ({bus_a.x, bus_a.y, bus_a.busy} !== 3'b101) begin
            n_err++;
            $display("FAIL abort pre-reset {x,y,busy}: got %b expected 101",
                     {bus_a.x, bus_a.y, bus_a.busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = sample(1'b0);
        n_vec++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL abort outputs during reset: got %b expected 0", o);
        end
        void'(sb_a.pop_back());
        last_r[0] = '0;
        last_r[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus_a.done || bus_a.busy) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort done/busy after release: got %0d cycles expected 0", dones);
        end
        sweep(1'b0, 4'b0111, 1'b0, "after_abort");
    endtask

    task automatic test_settle1();
        sweep(1'b1, 4'b0001, 1'b0, "nor_settle1");
        sweep(1'b1, 4'b1001, 1'b0, "xnor_settle1");
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        last_r[0] = '0;
        last_r[1] = '0;
        test_reset();
        test_gates();
        test_no_match();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_settle1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
